// File: rtl/simplex_threshold_apply.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : simplex_threshold_apply                                          |
// | Purpose  : Buffers vectors, pairs each with its threshold, emits            |
// |            max(v[i] - theta, 0) saturated to the positive signed range.     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module simplex_threshold_apply #(
    parameter int TAG_WIDTH   = 32,
    parameter int BLOCKLENGTH = 6,
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              vec_valid_in,
    output logic                              vec_ready_out,
    input  logic [TAG_WIDTH-1:0]              vec_tag_in,
    input  logic [DATA_WIDTH*BLOCKLENGTH-1:0] vec_data_in,
    input  logic                              thr_valid_in,
    output logic                              thr_ready_out,
    input  logic [TAG_WIDTH-1:0]              thr_tag_in,
    input  logic [DATA_WIDTH-1:0]             thr_in,
    input  logic                              ready_in,
    output logic                              valid_out,
    output logic [TAG_WIDTH-1:0]              tag_out,
    output logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_out,
    output logic                              busy,
    output logic                              tag_error
);

    localparam int                    c_AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                    c_VW   = DATA_WIDTH * BLOCKLENGTH;
    localparam logic [c_AW:0]         c_FULL = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] c_MAX  = {1'b0, {(DATA_WIDTH - 1){1'b1}}};

    logic [TAG_WIDTH-1:0] r_tag_mem [FIFO_DEPTH];
    logic [c_VW-1:0]      r_vec_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_AW:0]        r_count;
    logic                 r_valid;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [c_VW-1:0]      r_data;
    logic                 r_tag_error;

    logic                 w_not_empty;
    logic                 w_not_full;
    logic                 w_out_load;
    logic                 w_push;
    logic                 w_fire;
    logic [TAG_WIDTH-1:0] w_head_tag;
    logic [c_VW-1:0]      w_head_vec;
    logic [c_VW-1:0]      w_clip;

    assign w_not_empty   = (r_count != '0);
    assign w_not_full    = (r_count != c_FULL);
    assign w_out_load    = ~r_valid | ready_in;
    // Ready is gated by reset so nothing is handshaken while state is clearing.
    assign vec_ready_out = ~reset & w_not_full;
    assign thr_ready_out = ~reset & w_not_empty & w_out_load;
    assign w_push        = vec_valid_in & vec_ready_out;
    assign w_fire        = thr_valid_in & thr_ready_out;
    assign w_head_tag    = r_tag_mem[r_rd_ptr];
    assign w_head_vec    = r_vec_mem[r_rd_ptr];

    generate
        for (genvar gi = 0; gi < BLOCKLENGTH; gi++) begin : g_comp
            logic [DATA_WIDTH-1:0] w_h;
            logic [DATA_WIDTH:0]   w_diff;
            assign w_h    = w_head_vec[DATA_WIDTH*gi +: DATA_WIDTH];
            assign w_diff = {w_h[DATA_WIDTH-1], w_h} - {thr_in[DATA_WIDTH-1], thr_in};
            // Negative clips to zero; anything above the positive max saturates.
            assign w_clip[DATA_WIDTH*gi +: DATA_WIDTH] =
                w_diff[DATA_WIDTH]   ? '0    :
                w_diff[DATA_WIDTH-1] ? c_MAX : w_diff[DATA_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= vec_tag_in;
            r_vec_mem[r_wr_ptr] <= vec_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_tag       <= '0;
            r_data      <= '0;
            r_tag_error <= 1'b0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_tag   <= w_head_tag;
            r_data  <= w_clip;
            if (thr_tag_in != w_head_tag) r_tag_error <= 1'b1;
        end else if (r_valid & ready_in) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_out = r_valid;
    assign tag_out   = r_tag;
    assign data_out  = r_data;
    assign tag_error = r_tag_error;
    assign busy      = w_not_empty | r_valid;

endmodule
`default_nettype wire

// File: tb/tb_simplex_threshold_apply.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_simplex_threshold_apply                                       |
// | Purpose  : Scenario tests plus randomized traffic against a queue model.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_simplex_threshold_apply;

    localparam int TW = 32;
    localparam int BL = 4;
    localparam int DW = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          vec_valid_in;
    logic          vec_ready_out;
    logic [TW-1:0] vec_tag_in;
    logic [31:0]   vec_data_in;
    logic          thr_valid_in;
    logic          thr_ready_out;
    logic [TW-1:0] thr_tag_in;
    logic [DW-1:0] thr_in;
    logic          ready_in;
    logic          valid_out;
    logic [TW-1:0] tag_out;
    logic [31:0]   data_out;
    logic          busy;
    logic          tag_error;

    int errors = 0;
    int checks = 0;

    simplex_threshold_apply #(
        .TAG_WIDTH(TW), .BLOCKLENGTH(BL), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset),
        .vec_valid_in(vec_valid_in), .vec_ready_out(vec_ready_out),
        .vec_tag_in(vec_tag_in), .vec_data_in(vec_data_in),
        .thr_valid_in(thr_valid_in), .thr_ready_out(thr_ready_out),
        .thr_tag_in(thr_tag_in), .thr_in(thr_in),
        .ready_in(ready_in), .valid_out(valid_out), .tag_out(tag_out),
        .data_out(data_out), .busy(busy), .tag_error(tag_error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [TW-1:0] tag; logic [31:0] data; } entry_t;
    entry_t      m_q[$];
    logic        m_valid = 1'b0;
    logic [TW-1:0] m_tag = '0;
    logic [31:0] m_data = '0;
    logic        m_err = 1'b0;

    function automatic logic [31:0] clip_vec(input logic [31:0] v, input logic [7:0] t);
        logic [31:0] r;
        int d;
        r = '0;
        for (int i = 0; i < BL; i++) begin
            d = int'($signed(v[8*i +: 8])) - int'($signed(t));
            if (d < 0) d = 0;
            else if (d > 127) d = 127;
            r[8*i +: 8] = 8'(d);
        end
        return r;
    endfunction

    function automatic logic exp_vec_ready();
        return !reset && (m_q.size() != FD);
    endfunction

    function automatic logic exp_thr_ready();
        return !reset && (m_q.size() != 0) && (!m_valid || ready_in);
    endfunction

    // Applies the behavioural transition for the current inputs, then advances one edge.
    task automatic tick();
        logic push, fire;
        entry_t e;
        push = vec_valid_in && exp_vec_ready();
        fire = thr_valid_in && exp_thr_ready();
        if (reset) begin
            m_q.delete();
            m_valid = 1'b0; m_tag = '0; m_data = '0; m_err = 1'b0;
        end else begin
            if (fire) begin
                e = m_q.pop_front();
                m_valid = 1'b1;
                m_tag   = e.tag;
                m_data  = clip_vec(e.data, thr_in);
                if (thr_tag_in != e.tag) m_err = 1'b1;
            end else if (m_valid && ready_in) begin
                m_valid = 1'b0;
            end
            if (push) begin
                e.tag = vec_tag_in; e.data = vec_data_in;
                m_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vec_valid_in = 1'b0; vec_tag_in = '0; vec_data_in = '0;
        thr_valid_in = 1'b0; thr_tag_in = '0; thr_in = '0;
        ready_in = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        checks++; if (tag_out !== '0) begin errors++; $display("FAIL reset_tag: got %h want 0", tag_out); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
        checks++; if (tag_error !== 1'b0) begin errors++; $display("FAIL reset_tag_error: got %b want 0", tag_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (vec_ready_out !== 1'b0) begin errors++; $display("FAIL reset_vec_ready: got %b want 0", vec_ready_out); end
        checks++; if (thr_ready_out !== 1'b0) begin errors++; $display("FAIL reset_thr_ready: got %b want 0", thr_ready_out); end
        reset = 1'b0;
        #1;
        checks++; if (vec_ready_out !== 1'b1) begin errors++; $display("FAIL post_reset_vec_ready: got %b want 1", vec_ready_out); end
    endtask

    task automatic test_basic();
        vec_valid_in = 1'b1; vec_tag_in = 32'h11; vec_data_in = {8'h7F, 8'h05, 8'hFD, 8'h0A};
        #1;
        checks++; if (thr_ready_out !== 1'b0) begin errors++; $display("FAIL basic_no_comb_thr_ready: got %b want 0", thr_ready_out); end
        tick();
        vec_valid_in = 1'b0;
        thr_valid_in = 1'b1; thr_tag_in = 32'h11; thr_in = 8'd4;
        #1;
        checks++; if (thr_ready_out !== 1'b1) begin errors++; $display("FAIL basic_thr_ready: got %b want 1", thr_ready_out); end
        tick();
        thr_valid_in = 1'b0;
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", valid_out); end
        checks++; if (tag_out !== 32'h11) begin errors++; $display("FAIL basic_tag: got %h want 11", tag_out); end
        checks++; if (data_out !== 32'h7B010006) begin errors++; $display("FAIL basic_data: got %h want 7b010006", data_out); end
        checks++; if (data_out !== m_data) begin errors++; $display("FAIL basic_data_model: got %h want %h", data_out, m_data); end
        checks++; if (tag_error !== 1'b0) begin errors++; $display("FAIL basic_tag_error: got %b want 0", tag_error); end
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", valid_out); end
    endtask

    task automatic test_saturation();
        logic [31:0] want [2];
        logic [7:0]  th [2];
        want[0] = 32'h7F7F007F; want[1] = 32'h0;
        th[0] = 8'h80; th[1] = 8'h7F;
        for (int k = 0; k < 2; k++) begin
            vec_valid_in = 1'b1; vec_tag_in = 32'h50 + k; vec_data_in = {8'h01, 8'h00, 8'h80, 8'h7F};
            tick();
            vec_valid_in = 1'b0;
            thr_valid_in = 1'b1; thr_tag_in = 32'h50 + k; thr_in = th[k];
            tick();
            thr_valid_in = 1'b0;
            checks++; if (data_out !== want[k]) begin errors++; $display("FAIL sat_data%0d: got %h want %h", k, data_out, want[k]); end
        end
        tick();
    endtask

    task automatic test_fill();
        for (int k = 0; k < FD; k++) begin
            vec_valid_in = 1'b1; vec_tag_in = 32'h20 + k; vec_data_in = $urandom;
            tick();
        end
        checks++; if (vec_ready_out !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b want 0", vec_ready_out); end
        vec_tag_in = 32'h99;
        tick();
        vec_valid_in = 1'b0;
        for (int k = 0; k < FD; k++) begin
            thr_valid_in = 1'b1; thr_tag_in = m_q[0].tag; thr_in = 8'($urandom);
            tick();
            checks++; if (valid_out !== 1'b1 || tag_out !== 32'h20 + k) begin errors++; $display("FAIL fill_order%0d: got v=%b tag=%h want v=1 tag=%h", k, valid_out, tag_out, 32'h20 + k); end
            checks++; if (data_out !== m_data) begin errors++; $display("FAIL fill_data%0d: got %h want %h", k, data_out, m_data); end
            checks++; if (vec_ready_out !== 1'b1) begin errors++; $display("FAIL fill_ready_back%0d: got %b want 1", k, vec_ready_out); end
        end
        thr_valid_in = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL fill_empty: got busy=%b v=%b want 0 0", busy, valid_out); end
    endtask

    task automatic test_backpressure();
        logic [TW-1:0] held_tag;
        logic [31:0]   held_data;
        ready_in = 1'b0;
        vec_valid_in = 1'b1; vec_tag_in = 32'h30; vec_data_in = $urandom;
        tick();
        vec_valid_in = 1'b0;
        thr_valid_in = 1'b1; thr_tag_in = 32'h30; thr_in = 8'($urandom);
        tick();
        thr_valid_in = 1'b0;
        vec_valid_in = 1'b1; vec_tag_in = 32'h31; vec_data_in = $urandom;
        tick();
        vec_valid_in = 1'b0;
        held_tag = tag_out; held_data = data_out;
        checks++; if (held_tag !== 32'h30 || held_data !== m_data) begin errors++; $display("FAIL bp_first: got %h/%h want 30/%h", held_tag, held_data, m_data); end
        thr_valid_in = 1'b1; thr_tag_in = 32'h31; thr_in = 8'($urandom);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (thr_ready_out !== 1'b0) begin errors++; $display("FAIL bp_thr_ready%0d: got %b want 0", k, thr_ready_out); end
            tick();
            checks++; if (valid_out !== 1'b1 || tag_out !== held_tag || data_out !== held_data) begin errors++; $display("FAIL bp_hold%0d: got %b %h %h want 1 %h %h", k, valid_out, tag_out, data_out, held_tag, held_data); end
        end
        ready_in = 1'b1;
        #1;
        checks++; if (thr_ready_out !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", thr_ready_out); end
        tick();
        thr_valid_in = 1'b0;
        checks++; if (valid_out !== 1'b1 || tag_out !== 32'h31 || data_out !== m_data) begin errors++; $display("FAIL bp_release: got %b %h %h want 1 31 %h", valid_out, tag_out, data_out, m_data); end
        tick();
    endtask

    task automatic test_tag_mismatch();
        vec_valid_in = 1'b1; vec_tag_in = 32'h5; vec_data_in = $urandom;
        tick();
        vec_valid_in = 1'b0;
        thr_valid_in = 1'b1; thr_tag_in = 32'h6; thr_in = 8'($urandom);
        tick();
        thr_valid_in = 1'b0;
        checks++; if (tag_out !== 32'h5 || valid_out !== 1'b1) begin errors++; $display("FAIL mm_tag: got %h v=%b want 5 v=1", tag_out, valid_out); end
        checks++; if (tag_error !== 1'b1) begin errors++; $display("FAIL mm_error: got %b want 1", tag_error); end
        vec_valid_in = 1'b1; vec_tag_in = 32'h7; vec_data_in = $urandom;
        tick();
        vec_valid_in = 1'b0;
        thr_valid_in = 1'b1; thr_tag_in = 32'h7;
        tick();
        thr_valid_in = 1'b0;
        tick();
        checks++; if (tag_error !== 1'b1) begin errors++; $display("FAIL mm_sticky: got %b want 1", tag_error); end
    endtask

    task automatic test_reset_mid();
        ready_in = 1'b0;
        for (int k = 0; k < FD; k++) begin
            vec_valid_in = 1'b1; vec_tag_in = 32'h40 + k; vec_data_in = $urandom;
            tick();
        end
        vec_valid_in = 1'b0;
        thr_valid_in = 1'b1; thr_tag_in = 32'h40;
        tick();
        thr_valid_in = 1'b0;
        checks++; if (valid_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rm_pre: got v=%b busy=%b want 1 1", valid_out, busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ready_in = 1'b1;
        #1;
        checks++; if (valid_out !== 1'b0 || busy !== 1'b0 || thr_ready_out !== 1'b0) begin errors++; $display("FAIL rm_cleared: got v=%b busy=%b thr_rdy=%b want 0 0 0", valid_out, busy, thr_ready_out); end
        checks++; if (tag_error !== 1'b0) begin errors++; $display("FAIL rm_tag_error: got %b want 0", tag_error); end
        vec_valid_in = 1'b1; vec_tag_in = 32'h77; vec_data_in = {8'h00, 8'h10, 8'hF0, 8'h40};
        tick();
        vec_valid_in = 1'b0;
        thr_valid_in = 1'b1; thr_tag_in = 32'h77; thr_in = 8'h08;
        tick();
        thr_valid_in = 1'b0;
        checks++; if (tag_out !== 32'h77 || data_out !== 32'h00080038) begin errors++; $display("FAIL rm_after: got %h %h want 77 00080038", tag_out, data_out); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            vec_valid_in = ($urandom_range(0, 3) != 0);
            vec_tag_in   = $urandom;
            vec_data_in  = $urandom;
            thr_valid_in = ($urandom_range(0, 2) != 0);
            thr_in       = 8'($urandom);
            ready_in     = ($urandom_range(0, 3) != 0);
            if (m_q.size() != 0 && $urandom_range(0, 15) != 0) thr_tag_in = m_q[0].tag;
            else thr_tag_in = $urandom;
            #1;
            checks++; if (vec_ready_out !== exp_vec_ready() || thr_ready_out !== exp_thr_ready()) begin errors++; $display("FAIL rnd_ready c%0d: got %b%b want %b%b", c, vec_ready_out, thr_ready_out, exp_vec_ready(), exp_thr_ready()); end
            tick();
            checks++; if (valid_out !== m_valid || busy !== (m_valid || m_q.size() != 0) || tag_error !== m_err) begin errors++; $display("FAIL rnd_status c%0d: got v=%b busy=%b err=%b want %b %b %b", c, valid_out, busy, tag_error, m_valid, (m_valid || m_q.size() != 0), m_err); end
            if (m_valid) begin
                checks++; if (tag_out !== m_tag || data_out !== m_data) begin errors++; $display("FAIL rnd_out c%0d: got %h %h want %h %h", c, tag_out, data_out, m_tag, m_data); end
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_fill();
        test_backpressure();
        test_tag_mismatch();
        test_reset_mid();
        reset = 1'b1; tick(); reset = 1'b0;
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
